param_inst_cache: RTL and testbench

- Parametrised direct-mapped, read-only instruction cache between the pipeline fetch stage and the text memory bus.
- Successor to the fixed-geometry icache, with configurable line count and line size.
- Pipelined multi-word line refill that tolerates RAM waitrequest and read latency.
- Synchronous flush input for self-modifying-code and fence.i support.

---
 rtl/param_inst_cache.sv | 181 ++++++++++++++++++
 tb/tb_param_inst_cache.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/param_inst_cache.sv
// Direct-mapped, read-only instruction cache with configurable geometry.
// Refills one line at a time through a pipelined, in-order RAM read port.
module param_inst_cache #(
  parameter int LINES          = 64,
  parameter int WORDS_PER_LINE = 4,
  parameter int ADDR_WIDTH     = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] cache_address,
  input  logic                  cache_read_enable,
  input  logic                  cache_flush,
  output logic [31:0]           cache_inst,
  output logic                  cache_waitrequest,
  output logic                  cache_inst_valid,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic                  ram_read_enable,
  input  logic [31:0]           ram_read_data,
  input  logic                  ram_waitrequest,
  input  logic                  ram_read_data_valid
);

  localparam int OFF_B   = $clog2(WORDS_PER_LINE);
  localparam int IDX_W   = $clog2(LINES);
  localparam int TAG_LSB = 2 + OFF_B + IDX_W;
  localparam int TAG_W   = ADDR_WIDTH - TAG_LSB;
  localparam int CNT_W   = OFF_B + 1;
  localparam int WIDX_W  = IDX_W + OFF_B;
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ~(ADDR_WIDTH'(WORDS_PER_LINE * 4) - ADDR_WIDTH'(1));
  localparam logic [ADDR_WIDTH-1:0] WORD_STEP = ADDR_WIDTH'(4);

  typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, DRAIN = 2'd2} state_t;

  state_t                state_r, state_next_s;
  logic [LINES-1:0]      valid_r;
  logic [TAG_W-1:0]      tag_mem_r [LINES];
  logic [31:0]           data_mem_r [LINES*WORDS_PER_LINE];
  logic [ADDR_WIDTH-1:0] fill_base_r, ram_address_r;
  logic                  ram_read_enable_r;
  logic [CNT_W-1:0]      issued_cnt_r, ret_cnt_r;
  logic [31:0]           cache_inst_r;
  logic                  cache_inst_valid_r;

  logic [IDX_W-1:0]  req_idx_s, fill_idx_s;
  logic [TAG_W-1:0]  req_tag_s, fill_tag_s;
  logic [WIDX_W-1:0] req_word_s, fill_word_s;
  logic hit_s, ram_accept_s, last_issue_s, fill_ret_s, last_ret_s, any_ret_s;
  logic wait_s, accept_hit_s, start_fill_s, clear_valid_s, fill_done_s, stop_issue_s;
  logic unused_s;

  // {index, offset} is contiguous, so one slice addresses the data array directly
  assign req_idx_s   = cache_address[2+OFF_B +: IDX_W];
  assign req_tag_s   = cache_address[ADDR_WIDTH-1:TAG_LSB];
  assign req_word_s  = cache_address[2 +: WIDX_W];
  assign fill_idx_s  = fill_base_r[2+OFF_B +: IDX_W];
  assign fill_tag_s  = fill_base_r[ADDR_WIDTH-1:TAG_LSB];
  assign fill_word_s = fill_base_r[2 +: WIDX_W] + WIDX_W'(ret_cnt_r);
  assign unused_s    = ^{cache_address[1:0], fill_base_r[1:0]};

  // Tags live in flops beside the valid bits so the hit decision is same-cycle
  assign hit_s        = valid_r[req_idx_s] && (tag_mem_r[req_idx_s] == req_tag_s);
  assign ram_accept_s = ram_read_enable_r && !ram_waitrequest;
  assign last_issue_s = (issued_cnt_r == CNT_W'(WORDS_PER_LINE - 1));
  assign fill_ret_s   = (state_r == FILL) && ram_read_data_valid;
  assign last_ret_s   = fill_ret_s && (ret_cnt_r == CNT_W'(WORDS_PER_LINE - 1));
  assign any_ret_s    = ram_read_data_valid && (state_r != IDLE);

  assign cache_waitrequest = reset & wait_s;
  assign cache_inst        = cache_inst_r;
  assign cache_inst_valid  = cache_inst_valid_r;
  assign ram_address       = ram_address_r;
  assign ram_read_enable   = ram_read_enable_r;

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_r <= IDLE;
    else        state_r <= state_next_s;
  end

  // Next-state and control strobes; a flush beats a completing fill
  always_comb begin
    state_next_s  = state_r;
    wait_s        = 1'b1;
    accept_hit_s  = 1'b0;
    start_fill_s  = 1'b0;
    clear_valid_s = 1'b0;
    fill_done_s   = 1'b0;
    stop_issue_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (cache_flush) begin
          clear_valid_s = 1'b1;
        end else if (cache_read_enable) begin
          if (hit_s) begin
            wait_s       = 1'b0;
            accept_hit_s = 1'b1;
          end else begin
            start_fill_s = 1'b1;
            state_next_s = FILL;
          end
        end else begin
          wait_s = 1'b0;
        end
      end
      FILL: begin
        if (cache_flush) begin
          stop_issue_s = 1'b1;
          if (last_ret_s) begin
            clear_valid_s = 1'b1;
            state_next_s  = IDLE;
          end else begin
            state_next_s = DRAIN;
          end
        end else if (last_ret_s) begin
          fill_done_s  = 1'b1;
          state_next_s = IDLE;
        end else begin
          state_next_s = FILL;
        end
      end
      DRAIN: begin
        if (ret_cnt_r == issued_cnt_r) begin
          clear_valid_s = 1'b1;
          state_next_s  = IDLE;
        end else begin
          state_next_s = DRAIN;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // Valid bits
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)              valid_r <= '0;
    else if (clear_valid_s)  valid_r <= '0;
    else if (fill_done_s)    valid_r[fill_idx_s] <= 1'b1;
  end

  // Tag and data arrays (no reset: qualified by the valid bits)
  always_ff @(posedge clock) begin
    if (fill_done_s) tag_mem_r[fill_idx_s] <= fill_tag_s;
    if (fill_ret_s)  data_mem_r[fill_word_s] <= ram_read_data;
  end

  // Fetch response: synchronous data read on an accepted hit
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cache_inst_r       <= 32'h0000_0000;
      cache_inst_valid_r <= 1'b0;
    end else begin
      cache_inst_valid_r <= accept_hit_s;
      if (accept_hit_s) cache_inst_r <= data_mem_r[req_word_s];
    end
  end

  // Refill issue/return bookkeeping; a word on the bus in the flush cycle still counts as issued
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fill_base_r       <= '0;
      ram_address_r     <= '0;
      ram_read_enable_r <= 1'b0;
      issued_cnt_r      <= '0;
      ret_cnt_r         <= '0;
    end else if (start_fill_s) begin
      fill_base_r       <= cache_address & LINE_MASK;
      ram_address_r     <= cache_address & LINE_MASK;
      ram_read_enable_r <= 1'b1;
      issued_cnt_r      <= '0;
      ret_cnt_r         <= '0;
    end else begin
      if (ram_accept_s) begin
        issued_cnt_r <= issued_cnt_r + CNT_W'(1);
        if (!last_issue_s) ram_address_r <= ram_address_r + WORD_STEP;
      end
      if (stop_issue_s || (ram_accept_s && last_issue_s)) ram_read_enable_r <= 1'b0;
      if (any_ret_s) ret_cnt_r <= ret_cnt_r + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_param_inst_cache.sv
// Directed plus randomized bench for param_inst_cache (16 lines x 4 words) with
// a latency/stall-configurable RAM responder and a line-presence reference model.
module tb_param_inst_cache;
  localparam int LINES = 16;
  localparam int WPL   = 4;
  localparam int AW    = 32;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [AW-1:0] cache_address = '0;
  logic          cache_read_enable = 1'b0;
  logic          cache_flush = 1'b0;
  logic [31:0]   cache_inst;
  logic          cache_waitrequest, cache_inst_valid;
  logic [AW-1:0] ram_address;
  logic          ram_read_enable;
  logic [31:0]   ram_read_data = 32'h0;
  logic          ram_waitrequest = 1'b0;
  logic          ram_read_data_valid = 1'b0;

  param_inst_cache #(.LINES(LINES), .WORDS_PER_LINE(WPL), .ADDR_WIDTH(AW)) dut (
    .clock(clock), .reset(reset),
    .cache_address(cache_address), .cache_read_enable(cache_read_enable),
    .cache_flush(cache_flush), .cache_inst(cache_inst),
    .cache_waitrequest(cache_waitrequest), .cache_inst_valid(cache_inst_valid),
    .ram_address(ram_address), .ram_read_enable(ram_read_enable),
    .ram_read_data(ram_read_data), .ram_waitrequest(ram_waitrequest),
    .ram_read_data_valid(ram_read_data_valid)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  // RAM responder: decides stalls and returns in-order data 'lat' edges after accept
  int          lat = 2;
  bit          rand_stall = 1'b0;
  logic [31:0] stall_addr = 32'h0;
  int          stall_left = 0;
  int          stall_seen = 0;
  logic [31:0] ram_log[$];
  logic [31:0] resp_addr[$];
  longint      resp_due[$];
  longint      cyc = 0;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (!reset) begin
      resp_addr.delete();
      resp_due.delete();
      ram_read_data_valid = 1'b0;
      ram_read_data = 32'h0;
      ram_waitrequest = 1'b0;
    end else begin
      if (resp_due.size() > 0 && resp_due[0] <= cyc + 1) begin
        ram_read_data_valid = 1'b1;
        ram_read_data = mem_word(resp_addr[0]);
        void'(resp_addr.pop_front());
        void'(resp_due.pop_front());
      end else begin
        ram_read_data_valid = 1'b0;
        ram_read_data = $urandom;
      end
      if (ram_read_enable && stall_left > 0 && ram_address == stall_addr) begin
        ram_waitrequest = 1'b1;
        stall_left--;
        stall_seen++;
      end else if (rand_stall) begin
        ram_waitrequest = ($urandom_range(0, 3) == 0);
      end else begin
        ram_waitrequest = 1'b0;
      end
      if (ram_read_enable && !ram_waitrequest) begin
        ram_log.push_back(ram_address);
        resp_addr.push_back(ram_address);
        resp_due.push_back(cyc + 1 + lat);
      end
    end
  end

  // Reference model: which line (tag) each index currently holds
  bit          m_valid [LINES];
  logic [31:0] m_tag   [LINES];

  function automatic int m_idx(input logic [31:0] a);
    return int'((a / (WPL * 4)) % LINES);
  endfunction
  function automatic logic [31:0] m_tagof(input logic [31:0] a);
    return a / (WPL * 4 * LINES);
  endfunction
  function automatic bit m_hit(input logic [31:0] a);
    return m_valid[m_idx(a)] && (m_tag[m_idx(a)] == m_tagof(a));
  endfunction
  task automatic m_clear();
    for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
  endtask

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic fetch(input logic [31:0] a, input string tag, output int wait_cycles);
    bit exp_hit;
    int base_n;
    logic [31:0] line;
    exp_hit = m_hit(a);
    base_n  = ram_log.size();
    line    = a & ~(32'(WPL * 4) - 32'd1);
    cache_address = a;
    cache_read_enable = 1'b1;
    #1;
    chk({tag, "_wr_first"}, cache_waitrequest, !exp_hit);
    wait_cycles = 0;
    while (cache_waitrequest === 1'b1 && wait_cycles < 400) begin
      tick();
      wait_cycles++;
    end
    chk({tag, "_accepted"}, cache_waitrequest, 1'b0);
    tick();
    cache_read_enable = 1'b0;
    chk({tag, "_valid"}, cache_inst_valid, 1'b1);
    chk({tag, "_data"}, cache_inst, mem_word(a));
    chk({tag, "_ram_reads"}, ram_log.size() - base_n, exp_hit ? 0 : WPL);
    if (!exp_hit && ram_log.size() - base_n == WPL)
      for (int k = 0; k < WPL; k++)
        chk({tag, "_ram_addr"}, ram_log[base_n + k], line + 32'(4 * k));
    m_valid[m_idx(a)] = 1'b1;
    m_tag[m_idx(a)]   = m_tagof(a);
  endtask

  task automatic flush_idle(input logic [31:0] a);
    cache_address = a;
    cache_read_enable = 1'b1;
    cache_flush = 1'b1;
    #1;
    chk("flush_idle_wr", cache_waitrequest, 1'b1);
    tick();
    cache_flush = 1'b0;
    cache_read_enable = 1'b0;
    chk("flush_idle_no_accept", cache_inst_valid, 1'b0);
    m_clear();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, base_n;
    logic [31:0] a;
    m_clear();
    cache_address = 32'h100;
    cache_read_enable = 1'b1;
    repeat (3) tick();
    chk("rst_wr", cache_waitrequest, 1'b0);
    chk("rst_valid", cache_inst_valid, 1'b0);
    chk("rst_ram_re", ram_read_enable, 1'b0);
    chk("rst_ram_addr", ram_address, 32'h0);
    chk("rst_inst", cache_inst, 32'h0);
    cache_read_enable = 1'b0;
    reset = 1'b1;
    tick();

    // Cold miss with 2-cycle RAM latency: 4 issue + 2 latency + 1 request cycle
    fetch(32'h100, "cold", n);
    chk("cold_wait_cycles", n, 7);

    // Back-to-back hits on the resident line
    base_n = ram_log.size();
    for (int i = 1; i < WPL; i++) begin
      cache_address = 32'h100 + 32'(4 * i);
      cache_read_enable = 1'b1;
      #1;
      chk("b2b_wr", cache_waitrequest, 1'b0);
      chk("b2b_ram_re", ram_read_enable, 1'b0);
      tick();
      chk("b2b_valid", cache_inst_valid, 1'b1);
      chk("b2b_data", cache_inst, mem_word(32'h100 + 32'(4 * i)));
    end
    cache_read_enable = 1'b0;
    tick();
    chk("b2b_idle_valid", cache_inst_valid, 1'b0);
    chk("b2b_no_ram", ram_log.size() - base_n, 0);

    // Conflict eviction, then refill with the second word stalled for 3 cycles
    fetch(32'h500, "conflict", n);
    stall_addr = 32'h104;
    stall_left = 3;
    stall_seen = 0;
    fetch(32'h100, "stall_refill", n);
    chk("stall_cycles", stall_seen, 3);
    fetch(32'h10C, "stall_hit", n);

    // Flush in IDLE, then flush a fill with two reads outstanding
    flush_idle(32'h100);
    lat = 5;
    base_n = ram_log.size();
    cache_address = 32'h100;
    cache_read_enable = 1'b1;
    n = 0;
    while (ram_log.size() - base_n < 2 && n < 50) begin
      tick();
      n++;
    end
    cache_flush = 1'b1;
    tick();
    cache_flush = 1'b0;
    cache_read_enable = 1'b0;
    chk("fillflush_issued", ram_log.size() - base_n, 2);
    n = 0;
    while (cache_waitrequest === 1'b1 && n < 50) begin
      tick();
      n++;
    end
    chk("fillflush_drained", cache_waitrequest, 1'b0);
    chk("fillflush_no_more_reads", ram_log.size() - base_n, 2);
    chk("fillflush_resp_left", resp_due.size(), 0);
    chk("fillflush_no_valid", cache_inst_valid, 1'b0);
    m_clear();
    lat = 2;
    fetch(32'h100, "retry", n);

    // Asynchronous reset in the middle of a fill
    cache_address = 32'h300;
    cache_read_enable = 1'b1;
    repeat (3) tick();
    #2;
    reset = 1'b0;
    #1;
    chk("midrst_valid", cache_inst_valid, 1'b0);
    chk("midrst_wr", cache_waitrequest, 1'b0);
    chk("midrst_ram_re", ram_read_enable, 1'b0);
    chk("midrst_ram_addr", ram_address, 32'h0);
    chk("midrst_inst", cache_inst, 32'h0);
    cache_read_enable = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    m_clear();
    tick();
    fetch(32'h100, "post_rst", n);

    // Randomized traffic over a few conflicting tags with random RAM stalls
    rand_stall = 1'b1;
    for (int i = 0; i < 120; i++) begin
      lat = $urandom_range(1, 4);
      a = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 15)) << 4) |
          (32'($urandom_range(0, 3)) << 2);
      if ($urandom_range(0, 15) == 0) flush_idle(a);
      fetch(a, "rand", n);
      if ($urandom_range(0, 3) == 0) begin
        tick();
        chk("rand_gap_valid", cache_inst_valid, 1'b0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
